// File: rtl/core_id_ex_pipe.sv
// Decode-to-execute pipeline register with a 2-entry skid buffer and write-back operand bypass.
// Define CORE_WB_BYPASS_EN to enable capture-time bypass and snooping of held operands.
module core_id_ex_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic [4:0]            id_rd_addr,
  input  logic                  id_rd_we,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic [DATA_WIDTH-1:0] rf_read_data0,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic                  wb_we,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [4:0]            ex_rd_addr,
  output logic                  ex_rd_we,
  output logic [CTRL_WIDTH-1:0] ex_ctrl
);

`ifdef CORE_WB_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  // Bit 0 = main entry valid, bit 1 = skid entry valid.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic [1:0] state_q, state_d;
  logic       main_valid, skid_valid;
  logic       accept, rel;
  logic       load_main_in, load_skid, move_skid;

  logic [4:0]            id_rs_addr [2];
  logic [DATA_WIDTH-1:0] rf_data    [2];

  logic [DATA_WIDTH-1:0] main_pc_q, skid_pc_q;
  logic [DATA_WIDTH-1:0] main_imm_q, skid_imm_q;
  logic [4:0]            main_rd_addr_q, skid_rd_addr_q;
  logic                  main_rd_we_q, skid_rd_we_q;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, skid_ctrl_q;

  assign id_rs_addr = '{id_rs1_addr, id_rs2_addr};
  assign rf_data    = '{rf_read_data0, rf_read_data1};

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];
  assign id_ready   = !skid_valid;
  assign ex_valid   = main_valid;

  assign accept = id_valid && !skid_valid;
  assign rel    = main_valid && ex_ready;

  assign load_main_in = !flush && accept && (!main_valid || rel);
  assign load_skid    = !flush && accept && main_valid && !rel;
  assign move_skid    = !flush && skid_valid && rel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !rel)      state_d = FULL;
        else if (!accept && rel) state_d = EMPTY;
      end
      FULL:    if (rel) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc_q      <= '0;
      main_imm_q     <= '0;
      main_rd_addr_q <= '0;
      main_rd_we_q   <= 1'b0;
      main_ctrl_q    <= '0;
    end else if (load_main_in) begin
      main_pc_q      <= id_pc;
      main_imm_q     <= id_imm;
      main_rd_addr_q <= id_rd_addr;
      main_rd_we_q   <= id_rd_we;
      main_ctrl_q    <= id_ctrl;
    end else if (move_skid) begin
      main_pc_q      <= skid_pc_q;
      main_imm_q     <= skid_imm_q;
      main_rd_addr_q <= skid_rd_addr_q;
      main_rd_we_q   <= skid_rd_we_q;
      main_ctrl_q    <= skid_ctrl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_rd_addr_q <= '0;
      skid_rd_we_q   <= 1'b0;
      skid_ctrl_q    <= '0;
    end else if (load_skid) begin
      skid_pc_q      <= id_pc;
      skid_imm_q     <= id_imm;
      skid_rd_addr_q <= id_rd_addr;
      skid_rd_we_q   <= id_rd_we;
      skid_ctrl_q    <= id_ctrl;
    end
  end

  // One slice per source operand: index, captured value and write-back snoop.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [4:0]            main_rs_q, skid_rs_q;
    logic [DATA_WIDTH-1:0] main_op_q, main_op_d;
    logic [DATA_WIDTH-1:0] skid_op_q, skid_op_d;
    logic [DATA_WIDTH-1:0] cap_val, skid_snooped;
    logic                  cap_hit, main_hit, skid_hit;

    // x0 is hardwired, so a write-back to index 0 never corrects anything.
    assign cap_hit  = BYPASS_EN && wb_we && (wb_addr == id_rs_addr[gi]) && (id_rs_addr[gi] != 5'd0);
    assign main_hit = BYPASS_EN && wb_we && (wb_addr == main_rs_q) && (main_rs_q != 5'd0);
    assign skid_hit = BYPASS_EN && wb_we && (wb_addr == skid_rs_q) && (skid_rs_q != 5'd0);

    assign cap_val      = cap_hit  ? wb_data : rf_data[gi];
    assign skid_snooped = skid_hit ? wb_data : skid_op_q;

    always_comb begin
      main_op_d = main_op_q;
      if (load_main_in)             main_op_d = cap_val;
      else if (move_skid)           main_op_d = skid_snooped;
      else if (main_valid && main_hit) main_op_d = wb_data;
    end

    always_comb begin
      skid_op_d = skid_op_q;
      if (load_skid)                   skid_op_d = cap_val;
      else if (skid_valid && skid_hit) skid_op_d = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_rs_q <= '0;
        skid_rs_q <= '0;
        main_op_q <= '0;
        skid_op_q <= '0;
      end else begin
        main_op_q <= main_op_d;
        skid_op_q <= skid_op_d;
        if (load_main_in)   main_rs_q <= id_rs_addr[gi];
        else if (move_skid) main_rs_q <= skid_rs_q;
        if (load_skid)      skid_rs_q <= id_rs_addr[gi];
      end
    end
  end

  assign ex_pc       = main_pc_q;
  assign ex_imm      = main_imm_q;
  assign ex_rd_addr  = main_rd_addr_q;
  assign ex_rd_we    = main_rd_we_q;
  assign ex_ctrl     = main_ctrl_q;
  assign ex_rs1_data = g_opnd[0].main_op_q;
  assign ex_rs2_data = g_opnd[1].main_op_q;

endmodule

// File: tb/tb_core_id_ex_pipe.sv
// Scoreboard bench for core_id_ex_pipe: driver pushes expected bundles, monitor pops on each transfer.
module tb_core_id_ex_pipe;

`ifdef CORE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rd_we;
  logic [15:0] id_ctrl;
  logic [31:0] rf_read_data0, rf_read_data1;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic [15:0] ex_ctrl;

  core_id_ex_pipe #(.DATA_WIDTH(32), .CTRL_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_read_data0(rf_read_data0), .rf_read_data1(rf_read_data1),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        we;
    logic [15:0] ctrl;
  } bund_t;

  bund_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the next edge whenever ex_valid && ex_ready.
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle: got pc=%h expected no bundle", ex_pc);
      end else begin
        bund_t e;
        e = sb.pop_front();
        $display("txn pc=%h rs1=%h rs2=%h imm=%h rd=%0d we=%0b ctrl=%h",
                 ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd_addr, ex_rd_we, ex_ctrl);
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rs1_data", ex_rs1_data, e.rs1);
        chk("ex_rs2_data", ex_rs2_data, e.rs2);
        chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
        chk("ex_rd_we", {31'd0, ex_rd_we}, {31'd0, e.we});
        chk("ex_ctrl", {16'd0, ex_ctrl}, {16'd0, e.ctrl});
      end
    end
  end

  // Drives one bundle at posedge+1, waiting (bounded) for id_ready; returns at posedge+1 after accept.
  task automatic send(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] rf0, input logic [31:0] rf1,
                      input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                      input logic [31:0] e1, input logic [31:0] e2, input bit push);
    bund_t e;
    int n = 0;
    while (!id_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!id_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got id_ready=0 expected 1 within 50 cycles");
    end
    id_valid      = 1'b1;
    id_pc         = pc;
    id_imm        = pc ^ 32'h5A5A_0000;
    id_rs1_addr   = rs1;
    id_rs2_addr   = rs2;
    id_rd_addr    = pc[6:2];
    id_rd_we      = pc[2];
    id_ctrl       = pc[15:0] ^ 16'hC3C3;
    rf_read_data0 = rf0;
    rf_read_data1 = rf1;
    wb_we         = wbwe;
    wb_addr       = wba;
    wb_data       = wbd;
    e.pc   = pc;
    e.imm  = pc ^ 32'h5A5A_0000;
    e.rs1  = e1;
    e.rs2  = e2;
    e.rd   = pc[6:2];
    e.we   = pc[2];
    e.ctrl = pc[15:0] ^ 16'hC3C3;
    if (push) sb.push_back(e);
    tick(1);
    id_valid = 1'b0;
    wb_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_pc = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_rd_we = 1'b0; id_ctrl = '0;
    rf_read_data0 = '0; rf_read_data1 = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_ex_rs1", ex_rs1_data, 32'd0);
    chk("rst_ex_ctrl", {16'd0, ex_ctrl}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("idle_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("idle_id_ready", {31'd0, id_ready}, 32'd1);

    // Basic transfer, 1-cycle latency
    send(32'h100, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 5'd0, 32'd0, 32'h11, 32'h22, 1'b1);
    chk("lat_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("lat_ex_pc", ex_pc, 32'h100);
    tick(2);

    // Backpressure fills skid
    ex_ready = 1'b0;
    send(32'h100, 5'd1, 5'd2, 32'h31, 32'h32, 1'b0, 5'd0, 32'd0, 32'h31, 32'h32, 1'b1);
    send(32'h104, 5'd1, 5'd2, 32'h41, 32'h42, 1'b0, 5'd0, 32'd0, 32'h41, 32'h42, 1'b1);
    chk("full_id_ready", {31'd0, id_ready}, 32'd0);
    tick(2);
    chk("hold_ex_pc", ex_pc, 32'h100);
    chk("hold_id_ready", {31'd0, id_ready}, 32'd0);
    ex_ready = 1'b1;
    tick(1);
    chk("drain_ex_pc", ex_pc, 32'h104);
    tick(3);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Capture-time bypass
    send(32'h120, 5'd5, 5'd6, 32'hAAAA, 32'h66, 1'b1, 5'd5, 32'h1234,
         BYP ? 32'h1234 : 32'hAAAA, 32'h66, 1'b1);
    // x0 guard
    send(32'h124, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    tick(3);

    // Snoop of an entry held in skid
    ex_ready = 1'b0;
    send(32'h200, 5'd1, 5'd2, 32'hA1, 32'hA2, 1'b0, 5'd0, 32'd0, 32'hA1, 32'hA2, 1'b1);
    send(32'h204, 5'd8, 5'd7, 32'h70, 32'h77, 1'b0, 5'd0, 32'd0,
         32'h70, BYP ? 32'hBEEF : 32'h77, 1'b1);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hBEEF;
    tick(1);
    wb_we = 1'b0;
    tick(1);
    ex_ready = 1'b1;
    tick(4);

    // Snoop during skid-to-main move
    ex_ready = 1'b0;
    send(32'h210, 5'd10, 5'd11, 32'hB0, 32'hB1, 1'b0, 5'd0, 32'd0, 32'hB0, 32'hB1, 1'b1);
    send(32'h214, 5'd9, 5'd12, 32'h90, 32'h91, 1'b0, 5'd0, 32'd0,
         BYP ? 32'hC0DE : 32'h90, 32'h91, 1'b1);
    ex_ready = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hC0DE;
    tick(1);
    wb_we = 1'b0;
    tick(3);
    chk("snoop_sb_empty", sb.size(), 32'd0);

    // Flush while FULL with a simultaneous incoming bundle
    ex_ready = 1'b0;
    send(32'h300, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 5'd0, 32'd0, 32'h1, 32'h2, 1'b0);
    send(32'h304, 5'd1, 5'd2, 32'h3, 32'h4, 1'b0, 5'd0, 32'd0, 32'h3, 32'h4, 1'b0);
    chk("pre_flush_id_ready", {31'd0, id_ready}, 32'd0);
    flush = 1'b1; id_valid = 1'b1; id_pc = 32'h308;
    tick(1);
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_id_ready", {31'd0, id_ready}, 32'd1);
    ex_ready = 1'b1;
    tick(3);
    chk("flush_stays_empty", {31'd0, ex_valid}, 32'd0);
    send(32'h30C, 5'd13, 5'd14, 32'hD0, 32'hD1, 1'b0, 5'd0, 32'd0, 32'hD0, 32'hD1, 1'b1);
    tick(2);

    // Asynchronous reset mid-transfer
    ex_ready = 1'b0;
    send(32'h400, 5'd1, 5'd2, 32'h5, 32'h6, 1'b0, 5'd0, 32'd0, 32'h5, 32'h6, 1'b0);
    chk("pre_rst_ex_valid", {31'd0, ex_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("async_rst_ex_pc", ex_pc, 32'd0);
    tick(1);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    tick(2);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_id_ex_pipe.md
Name: core_id_ex_pipe

Overview:
- Decode-to-execute pipeline register: sits directly downstream of the register file.
- Captures the decode bundle together with the two register-file read operands and presents it to the execute stage over a valid/ready handshake.
- A 2-entry skid buffer keeps the ready path registered.
- Write-back bypass corrects operands that the register file returns stale, because it only commits writes at the clock edge.

Parameters:
- DATA_WIDTH, core_pkg value (32), operand/PC/immediate width.
- CTRL_WIDTH, 16, opaque execute control bundle width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode bundle valid
- id_ready  out  1  pipe can accept a bundle
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_addr  in  5  source 1 index, also drives register-file read_addr0
- id_rs2_addr  in  5  source 2 index, also drives register-file read_addr1
- id_rd_addr  in  5  destination index
- id_rd_we  in  1  instruction writes rd
- id_imm  in  DATA_WIDTH  decoded immediate
- id_ctrl  in  CTRL_WIDTH  execute control
- rf_read_data0  in  DATA_WIDTH  register-file port 0 data
- rf_read_data1  in  DATA_WIDTH  register-file port 1 data
- wb_we  in  1  write-back write enable (same net as register-file we)
- wb_addr  in  5  write-back address
- wb_data  in  DATA_WIDTH  write-back data
- flush  in  1  squash all held bundles
- ex_valid  out  1  execute bundle valid
- ex_ready  in  1  execute accepts bundle
- ex_pc, ex_imm  out  DATA_WIDTH each  registered copies
- ex_rs1_data, ex_rs2_data  out  DATA_WIDTH each  operands
- ex_rd_addr  out  5  registered copy
- ex_rd_we  out  1  registered copy
- ex_ctrl  out  CTRL_WIDTH  registered copy

Behaviour:
- Reset: asynchronous on rst_n low.
  - All valid bits 0 and all payload registers 0.
  - Outputs after reset: ex_valid=0, id_ready=1, all ex_* payload 0.
- Storage: main entry (drives ex_*) plus skid entry.
- States: EMPTY (none valid), ONE (main valid), FULL (main and skid valid).
- id_ready = !skid_valid. It is a register output with no combinational path from ex_ready.
- Accept = id_valid && id_ready. Release = ex_valid && ex_ready.
- Transitions:
  - EMPTY, accept -> ONE. Bundle visible on ex_* next cycle (1-cycle latency).
  - ONE, accept && release -> ONE, main loaded with the new bundle.
  - ONE, accept && !release -> FULL, new bundle into skid.
  - ONE, release && !accept -> EMPTY.
  - FULL, release -> ONE, skid moves to main. id_ready returns to 1 the following cycle.
  - FULL, no release -> hold. Accept is impossible because id_ready=0.
- Operand capture: operand = wb_data if wb_we && wb_addr==rsN && rsN!=0; otherwise rf_read_data(N-1).
- Snoop: every cycle, each valid held entry with wb_we && wb_addr==its rsN && rsN!=0 overwrites its operand N with wb_data. This applies to main and skid independently.
- Snoop during skid-to-main move: the moved entry is snooped in the same cycle, so the value landing in main is already corrected.
- x0: index 0 is never bypassed or snooped. The operand stays 0.
- Flush:
  - Next edge clears both valid bits and forces EMPTY.
  - Overrides a simultaneous accept; the incoming bundle is dropped.
  - Payload registers may retain stale data, but ex_valid=0.
- Reset mid-operation: immediate return to EMPTY regardless of the handshake.
- Payload registers load only on accept or skid-to-main move, plus snoop updates of operand fields. They hold otherwise.

Optional Feature:
- Macro: CORE_WB_BYPASS_EN.
- Defined: capture-time bypass and held-entry snoop exactly as specified above.
- Undefined: operands come straight from rf_read_data0/1 and are never modified while held. The wb_* inputs are unused, and RAW hazards are left to the hazard unit.

Test Plan:
- Reset with ex_ready=1, then send bundle pc=0x100, rs1=3, rs2=4 while regfile returns 0x11/0x22 -> next cycle ex_valid=1, ex_pc=0x100, ex_rs1_data=0x11, ex_rs2_data=0x22. Before the bundle arrives, ex_valid=0 and id_ready=1.
- Backpressure: ex_ready=0, send pc=0x100 then 0x104 -> id_ready=0 after the second accept. Set ex_ready=1 -> ex_pc=0x100 then 0x104 on consecutive cycles, with no loss or duplication.
- Capture bypass (macro on): rs1=5, rf_read_data0=0xAAAA, same cycle wb_we=1, wb_addr=5, wb_data=0x1234 -> ex_rs1_data=0x1234.
- Held snoop (macro on): bundle with rs2=7 held in skid under ex_ready=0, then wb writes x7=0xBEEF -> after release, ex_rs2_data=0xBEEF.
- x0 guard: rs1=0 with wb_we=1, wb_addr=0, wb_data=0xFFFF_FFFF -> ex_rs1_data=0.
- Flush while FULL, with id_valid=1 in the same cycle -> next cycle ex_valid=0 and id_ready=1, and the flushed bundles never appear. Asserting rst_n low mid-transfer immediately drives ex_valid=0.
